// File: rtl/jtdd_pkg.sv
// Shared types and constants for the jtdd graphics ROM arbiter.
package jtdd_pkg;

    localparam int ROMARB_SLOTS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } romarb_state_t;

    typedef logic [1:0] slot_idx_t;

    // Next slot index in round-robin order, wrapping after the last slot.
    function automatic slot_idx_t slot_next(input slot_idx_t s);
        return (s >= slot_idx_t'(ROMARB_SLOTS - 1)) ? slot_idx_t'(0) : s + slot_idx_t'(1);
    endfunction

endpackage

// File: rtl/jtdd_rom_arb_if.sv
// Memory read port shared by the ROM arbiter (master) and the SDRAM/ROM
// controller (slave). mem_req is held until the one-cycle mem_ok acknowledge.
interface jtdd_rom_arb_if #(
    parameter int DW  = 8,
    parameter int MAW = 22
);
    logic [MAW-1:0] mem_addr;
    logic           mem_req;
    logic [DW-1:0]  mem_data;
    logic           mem_ok;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_data,
        input  mem_ok
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_data,
        output mem_ok
    );
endinterface

// File: rtl/jtdd_rom_slot.sv
// One cached requester slot: remembers the last fetched address/word and
// compares it combinationally against the requester's current address.
module jtdd_rom_slot #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] data,
    output logic          ok,
    output logic          pending
);
    logic          valid;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic          hit;

    // Cache fill on the arbiter's completion strobe; reset empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            caddr <= '0;
            cdata <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            caddr <= wr_addr;
            cdata <= wr_data;
        end
    end

    assign hit     = valid && (addr == caddr);
    assign ok      = cs && hit;
    assign pending = cs && !hit;
    assign data    = cdata;

endmodule

// File: rtl/jtdd_rom_arb.sv
// Three-slot graphics ROM fetch arbiter (char, scroll, object layers) sharing
// one memory read port. Each slot caches its last word; a slot whose address
// differs from its cache (or is empty) is fetched, one transaction at a time.
// Build option JTDD_ROMARB_PRIO_EN: fixed priority 0 > 1 > 2 instead of
// round-robin; the round-robin pointer is then not built.
module jtdd_rom_arb
    import jtdd_pkg::*;
#(
    parameter int             AW      = 15,
    parameter int             DW      = 8,
    parameter int             MAW     = 22,
    parameter logic [MAW-1:0] OFFSET0 = '0,
    parameter logic [MAW-1:0] OFFSET1 = '0,
    parameter logic [MAW-1:0] OFFSET2 = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs0,
    input  logic            cs1,
    input  logic            cs2,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [AW-1:0]   addr2,
    output logic [DW-1:0]   data0,
    output logic [DW-1:0]   data1,
    output logic [DW-1:0]   data2,
    output logic            ok0,
    output logic            ok1,
    output logic            ok2,
    jtdd_rom_arb_if.master  mem
);
    romarb_state_t           state, state_nxt;
    slot_idx_t               gslot, gslot_nxt;
    logic [AW-1:0]           gaddr, gaddr_nxt;
    logic [MAW-1:0]          mem_addr_q, mem_addr_nxt;
    logic                    mem_req_q, mem_req_nxt;
    logic                    fill;
    logic [ROMARB_SLOTS-1:0] pend;
    logic                    found;
    slot_idx_t               gsel;
    logic [AW-1:0]           addr_sel;
    logic [MAW-1:0]          offset_sel;
`ifndef JTDD_ROMARB_PRIO_EN
    slot_idx_t               ptr, ptr_nxt;
    slot_idx_t               cand;
`endif

    jtdd_rom_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk(clk), .rst(rst), .cs(cs0), .addr(addr0),
        .wr_en(fill && gslot == 2'd0), .wr_addr(gaddr), .wr_data(mem.mem_data),
        .data(data0), .ok(ok0), .pending(pend[0])
    );

    jtdd_rom_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk(clk), .rst(rst), .cs(cs1), .addr(addr1),
        .wr_en(fill && gslot == 2'd1), .wr_addr(gaddr), .wr_data(mem.mem_data),
        .data(data1), .ok(ok1), .pending(pend[1])
    );

    jtdd_rom_slot #(.AW(AW), .DW(DW)) u_slot2 (
        .clk(clk), .rst(rst), .cs(cs2), .addr(addr2),
        .wr_en(fill && gslot == 2'd2), .wr_addr(gaddr), .wr_data(mem.mem_data),
        .data(data2), .ok(ok2), .pending(pend[2])
    );

    // Grant selection: first pending slot in priority or round-robin order.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
`ifdef JTDD_ROMARB_PRIO_EN
        for (int i = 0; i < ROMARB_SLOTS; i++) begin
            if (!found && pend[i]) begin
                found = 1'b1;
                gsel  = slot_idx_t'(i);
            end
        end
`else
        cand = ptr;
        for (int i = 0; i < ROMARB_SLOTS; i++) begin
            if (!found && pend[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
            cand = slot_next(cand);
        end
`endif
    end

    // Address and base offset of the selected slot; the sum wraps at MAW bits.
    always_comb begin
        addr_sel   = addr0;
        offset_sel = OFFSET0;
        case (gsel)
            2'd1: begin
                addr_sel   = addr1;
                offset_sel = OFFSET1;
            end
            2'd2: begin
                addr_sel   = addr2;
                offset_sel = OFFSET2;
            end
            default: begin
                addr_sel   = addr0;
                offset_sel = OFFSET0;
            end
        endcase
    end

    // FSM next state: issue one fetch from IDLE, complete it on mem_ok in WAIT.
    always_comb begin
        state_nxt    = state;
        gslot_nxt    = gslot;
        gaddr_nxt    = gaddr;
        mem_addr_nxt = mem_addr_q;
        mem_req_nxt  = mem_req_q;
        fill         = 1'b0;
`ifndef JTDD_ROMARB_PRIO_EN
        ptr_nxt      = ptr;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    gslot_nxt    = gsel;
                    gaddr_nxt    = addr_sel;
                    mem_addr_nxt = offset_sel + MAW'(addr_sel);
                    mem_req_nxt  = 1'b1;
                    state_nxt    = WAIT;
`ifndef JTDD_ROMARB_PRIO_EN
                    ptr_nxt      = slot_next(gsel);
`endif
                end
            end
            WAIT: begin
                if (mem.mem_ok) begin
                    fill        = 1'b1;
                    mem_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    // FSM and request registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gslot      <= '0;
            gaddr      <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
`ifndef JTDD_ROMARB_PRIO_EN
            ptr        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            gslot      <= gslot_nxt;
            gaddr      <= gaddr_nxt;
            mem_addr_q <= mem_addr_nxt;
            mem_req_q  <= mem_req_nxt;
`ifndef JTDD_ROMARB_PRIO_EN
            ptr        <= ptr_nxt;
`endif
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_req  = mem_req_q;

endmodule
